i2c_reg_seq: RTL and testbench
==============================

I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 200000: CLK_100MHz cycles allowed per engine handshake phase before abort.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on i2c_ready.
REQ-003 SHALL use one clock, CLK_100MHz; reset is synchronous and active-low.
REQ-004 Ports:
- CLK_100MHz  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  host command request
- cmd_ready  out  1  sequencer can accept a command
- cmd_rw  in  1  0 = register write, 1 = register read
- cmd_dev  in  7  I2C device address
- cmd_reg  in  8  register pointer
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data, valid with rsp_valid
- rsp_err  out  1  timeout abort flag, valid with rsp_valid
- i2c_addr  out  7  to byte engine addr
- i2c_data  out  8  to byte engine data_in
- i2c_rw  out  1  to byte engine rw
- i2c_enable  out  1  to byte engine enable
- i2c_ready  in  1  from byte engine ready (slow-clock domain)
- i2c_rdata  in  8  from byte engine data_out

Function
REQ-005 SHALL pass i2c_ready through a SYNC_STAGES-flop synchronizer (rdy_s); all decisions SHALL use rdy_s only.
REQ-006 SHALL have states IDLE, REQ_PTR, WAIT_PTR, REQ_DATA, WAIT_DATA, RESP.
REQ-007 cmd_ready SHALL be 1 only in IDLE and only when rdy_s = 1; a command is accepted on cmd_valid && cmd_ready, latching cmd_rw/dev/reg/wdata, then moving to REQ_PTR.
REQ-008 REQ_PTR: drive i2c_addr = dev, i2c_rw = 0, i2c_data = reg, i2c_enable = 1; on rdy_s = 0, deassert i2c_enable and go to WAIT_PTR.
REQ-009 WAIT_PTR: on rdy_s = 1, go to REQ_DATA.
REQ-010 REQ_DATA: drive i2c_addr = dev, i2c_rw = latched rw, i2c_data = wdata (write) or 0x00 (read), i2c_enable = 1; on rdy_s = 0, deassert i2c_enable and go to WAIT_DATA.
REQ-011 WAIT_DATA: on rdy_s = 1, latch rsp_rdata = i2c_rdata if read (unchanged if write), rsp_err = 0, go to RESP.
REQ-012 RESP: assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-013 i2c_enable SHALL be 0 in every state other than REQ_PTR and REQ_DATA.
REQ-014 Timeout counter (width ceil(log2(TIMEOUT_CYCLES+1))) SHALL clear on every state entry and increment each cycle in REQ_*/WAIT_*; at count = TIMEOUT_CYCLES-1 go to RESP with rsp_err = 1 and i2c_enable = 0, no wrap.
REQ-015 Timeout and rdy_s transition in the same cycle: the rdy_s transition SHALL win.
REQ-016 cmd_valid outside accept SHALL be ignored; no command queuing.
REQ-017 Latched command fields SHALL be stable from accept until RESP.

Reset
REQ-018 On rst_n = 0 at a clock edge: state = IDLE, i2c_enable = 0, i2c_addr = 0, i2c_data = 0, i2c_rw = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, timeout counter = 0, synchronizer flops = 1.
REQ-019 Reset mid-transaction SHALL abort without emitting rsp_valid; cmd_ready SHALL rise once rdy_s = 1.

Structure
REQ-020 State encodings and default TIMEOUT_CYCLES SHALL be defined in shared package i2c_pkg.
REQ-021 The synchronizer SHALL be sub-module sync_ff (parameterized depth, reset value 1).

Verification
REQ-022 Write dev 0x3C, reg 0x10, wdata 0xA5 against an engine model (ACK, ready low 4000 cycles per byte) -> two engine enables with (0x3C, rw 0, 0x10) then (0x3C, rw 0, 0xA5); rsp_valid once, rsp_err = 0.
REQ-023 Read dev 0x68, reg 0x75, model returns 0x71 -> enables (0x68, 0, 0x75) then (0x68, 1); rsp_rdata = 0x71, rsp_err = 0.
REQ-024 Model holds i2c_ready = 1 forever after enable, TIMEOUT_CYCLES = 1000 -> i2c_enable drops after 1000 cycles, rsp_valid with rsp_err = 1, return to IDLE.
REQ-025 rst_n low for 1 cycle during WAIT_DATA -> i2c_enable = 0 next cycle, no rsp_valid, cmd_ready = 1 after model returns ready.
REQ-026 cmd_valid held high continuously with two back-to-back commands -> second accepted only after first rsp_valid; cmd_ready = 0 throughout the first transaction.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register sequencer: FSM state encodings,
// default timing parameters and a small state classification helper.
package i2c_pkg;

    // Engine-phase watchdog, in CLK_100MHz cycles.
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 200000;
    // Depth of the i2c_ready synchronizer.
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ_PTR   = 3'd1,
        WAIT_PTR  = 3'd2,
        REQ_DATA  = 3'd3,
        WAIT_DATA = 3'd4,
        RESP      = 3'd5
    } state_t;

    // States in which the watchdog runs.
    function automatic logic in_engine_phase(input state_t s);
        return (s == REQ_PTR) || (s == WAIT_PTR) ||
               (s == REQ_DATA) || (s == WAIT_DATA);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single slow-domain level.
// Ports: clk, rst_n (sync, active-low), d (async in), q (synced out).
module sync_ff #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    // Shift toward the MSB; the MSB is the synchronized output.
    always_comb begin
        sync_d = (sync_q << 1) | DEPTH'(d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/i2c_reg_seq.sv
// Register read/write sequencer driving a byte-level I2C engine: a pointer
// byte then a data byte, with a per-phase watchdog that aborts stuck
// handshakes.
// Ports: host cmd_* request / rsp_* completion, i2c_* engine handshake
// (i2c_ready arrives from a slower clock domain and is synchronized).
module i2c_reg_seq
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEFAULT
) (
    input  logic       CLK_100MHz,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_data,
    output logic       i2c_rw,
    output logic       i2c_enable,
    input  logic       i2c_ready,
    input  logic [7:0] i2c_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);

    logic rdy_s;

    state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       rw_q, rw_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] wdata_q, wdata_d;

    logic [6:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       irw_q, irw_d;
    logic       en_q, en_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_err_q, rsp_err_d;

    logic       timeout;

    sync_ff #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_rdy_sync (
        .clk   (CLK_100MHz),
        .rst_n (rst_n),
        .d     (i2c_ready),
        .q     (rdy_s)
    );

    assign cmd_ready = (state_q == IDLE) && rdy_s;
    assign timeout   = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        dev_d       = dev_q;
        ptr_d       = ptr_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        data_d      = data_q;
        irw_d       = irw_q;
        en_d        = en_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                en_d = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    rw_d    = cmd_rw;
                    dev_d   = cmd_dev;
                    ptr_d   = cmd_reg;
                    wdata_d = cmd_wdata;
                    addr_d  = cmd_dev;
                    data_d  = cmd_reg;
                    irw_d   = 1'b0;
                    en_d    = 1'b1;
                    state_d = REQ_PTR;
                end
            end
            // Ready dropping means the engine took the byte; it takes
            // priority over a watchdog expiry in the same cycle.
            REQ_PTR: begin
                if (!rdy_s) begin
                    en_d    = 1'b0;
                    state_d = WAIT_PTR;
                end else if (timeout) begin
                    en_d        = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            WAIT_PTR: begin
                if (rdy_s) begin
                    addr_d  = dev_q;
                    irw_d   = rw_q;
                    data_d  = rw_q ? 8'h00 : wdata_q;
                    en_d    = 1'b1;
                    state_d = REQ_DATA;
                end else if (timeout) begin
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            REQ_DATA: begin
                if (!rdy_s) begin
                    en_d    = 1'b0;
                    state_d = WAIT_DATA;
                end else if (timeout) begin
                    en_d        = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            WAIT_DATA: begin
                if (rdy_s) begin
                    if (rw_q) begin
                        rsp_rdata_d = i2c_rdata;
                    end
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (timeout) begin
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                en_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                en_d    = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Watchdog restarts on every state change.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (in_engine_phase(state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            dev_q       <= '0;
            ptr_q       <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            irw_q       <= 1'b0;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            dev_q       <= dev_d;
            ptr_q       <= ptr_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            irw_q       <= irw_d;
            en_q        <= en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign i2c_addr   = addr_q;
    assign i2c_data   = data_q;
    assign i2c_rw     = irw_q;
    assign i2c_enable = en_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;

    // Pointer is kept for the whole transaction alongside the other
    // latched fields even though only the first byte consumes it.
    logic unused_ptr;
    assign unused_ptr = ^ptr_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq: write, read, watchdog abort,
// mid-transaction reset and back-to-back commands against an engine model.
module tb_i2c_reg_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_valid_to = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev = '0;
    logic [7:0] cmd_reg = '0;
    logic [7:0] cmd_wdata = '0;

    logic       cmd_ready, rsp_valid, rsp_err;
    logic [7:0] rsp_rdata, i2c_data;
    logic [6:0] i2c_addr;
    logic       i2c_rw, i2c_enable;
    logic       i2c_ready = 1'b1;
    logic [7:0] i2c_rdata = '0;

    logic       cmd_ready_to, rsp_valid_to, rsp_err_to;
    logic [7:0] rsp_rdata_to, i2c_data_to;
    logic [6:0] i2c_addr_to;
    logic       i2c_rw_to, i2c_enable_to;
    logic       i2c_ready_to = 1'b1;
    logic [7:0] i2c_rdata_to = '0;

    i2c_reg_seq u_dut (
        .CLK_100MHz (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rw     (cmd_rw),
        .cmd_dev    (cmd_dev),
        .cmd_reg    (cmd_reg),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .i2c_addr   (i2c_addr),
        .i2c_data   (i2c_data),
        .i2c_rw     (i2c_rw),
        .i2c_enable (i2c_enable),
        .i2c_ready  (i2c_ready),
        .i2c_rdata  (i2c_rdata)
    );

    i2c_reg_seq #(.TIMEOUT_CYCLES(1000)) u_to (
        .CLK_100MHz (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid_to),
        .cmd_ready  (cmd_ready_to),
        .cmd_rw     (cmd_rw),
        .cmd_dev    (cmd_dev),
        .cmd_reg    (cmd_reg),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid_to),
        .rsp_rdata  (rsp_rdata_to),
        .rsp_err    (rsp_err_to),
        .i2c_addr   (i2c_addr_to),
        .i2c_data   (i2c_data_to),
        .i2c_rw     (i2c_rw_to),
        .i2c_enable (i2c_enable_to),
        .i2c_ready  (i2c_ready_to),
        .i2c_rdata  (i2c_rdata_to)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Engine model: accepts a byte when enabled and ready, holds ready
    // low for low_len cycles, then returns ready with eng_rval.
    int         low_len = 4000;
    logic [7:0] eng_rval = '0;
    logic       eng_busy = 1'b0;
    int         eng_left = 0;
    int         eng_cnt = 0;
    logic [15:0] eng_log [0:15];

    always @(negedge clk) begin
        if (eng_busy) begin
            if (eng_left <= 1) begin
                i2c_ready <= 1'b1;
                i2c_rdata <= eng_rval;
                eng_busy  <= 1'b0;
            end
            eng_left <= eng_left - 1;
        end else if (i2c_enable && i2c_ready) begin
            if (eng_cnt < 16) begin
                eng_log[eng_cnt] <= {i2c_rw, i2c_addr, i2c_data};
            end
            eng_cnt   <= eng_cnt + 1;
            i2c_ready <= 1'b0;
            eng_busy  <= 1'b1;
            eng_left  <= low_len;
        end
    end

    int         rsp_cnt = 0;
    logic [7:0] last_rdata = '0;
    logic       last_err = 1'b0;
    int         rsp_cnt_to = 0;
    logic       last_err_to = 1'b0;
    int         en_hi_to = 0;

    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_cnt    <= rsp_cnt + 1;
            last_rdata <= rsp_rdata;
            last_err   <= rsp_err;
        end
        if (rsp_valid_to) begin
            rsp_cnt_to  <= rsp_cnt_to + 1;
            last_err_to <= rsp_err_to;
        end
        if (i2c_enable_to) begin
            en_hi_to <= en_hi_to + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        while (!(cmd_ready && cmd_valid) && n < 20000) begin
            tick();
            n++;
        end
        check({tag, "_bound"}, 32'(n < 20000), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rw, input logic [6:0] dev,
                        input logic [7:0] rg, input logic [7:0] wd);
        cmd_rw    = rw;
        cmd_dev   = dev;
        cmd_reg   = rg;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        wait_accept("accept");
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int target);
        int n = 0;
        while (rsp_cnt < target && n < 20000) begin
            tick();
            n++;
        end
        check({tag, "_bound"}, 32'(n < 20000), 32'd1);
    endtask

    initial begin
        int n;
        int rdy_bad;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tick();

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_enable", 32'(i2c_enable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_addr", 32'(i2c_addr), 32'h00);
        check("rst_data", 32'(i2c_data), 32'h00);
        check("rst_rw", 32'(i2c_rw), 32'd0);

        // Register write
        low_len = 4000;
        send(1'b0, 7'h3C, 8'h10, 8'hA5);
        wait_rsp("wr_rsp", 1);
        check("wr_eng_cnt", 32'(eng_cnt), 32'd2);
        check("wr_byte0", 32'(eng_log[0]), 32'h3C10);
        check("wr_byte1", 32'(eng_log[1]), 32'h3CA5);
        check("wr_err", 32'(last_err), 32'd0);
        check("wr_rdata_kept", 32'(rsp_rdata), 32'h00);
        tick();
        check("wr_rsp_once", 32'(rsp_cnt), 32'd1);
        check("wr_idle_ready", 32'(cmd_ready), 32'd1);

        // Register read
        low_len  = 300;
        eng_rval = 8'h71;
        send(1'b1, 7'h68, 8'h75, 8'hEE);
        wait_rsp("rd_rsp", 2);
        check("rd_eng_cnt", 32'(eng_cnt), 32'd4);
        check("rd_byte0", 32'(eng_log[2]), 32'h6875);
        check("rd_byte1", 32'(eng_log[3]), 32'hE800);
        check("rd_rdata", 32'(last_rdata), 32'h71);
        check("rd_err", 32'(last_err), 32'd0);
        tick();
        check("rd_rsp_once", 32'(rsp_cnt), 32'd2);

        // Reset during WAIT_DATA
        eng_rval = 8'h33;
        send(1'b1, 7'h50, 8'h01, 8'h00);
        n = 0;
        while (eng_cnt < 6 && n < 5000) begin
            tick();
            n++;
        end
        check("mr_second_byte", 32'(eng_cnt), 32'd6);
        n = 0;
        while (i2c_enable && n < 100) begin
            tick();
            n++;
        end
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_enable_low", 32'(i2c_enable), 32'd0);
        check("mr_no_rsp_now", 32'(rsp_valid), 32'd0);
        n = 0;
        while (!i2c_ready && n < 5000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mr_no_rsp", 32'(rsp_cnt), 32'd2);
        check("mr_no_enable", 32'(eng_cnt), 32'd6);

        // Back-to-back commands with cmd_valid held high
        low_len   = 200;
        eng_rval  = 8'h9C;
        cmd_rw    = 1'b0;
        cmd_dev   = 7'h20;
        cmd_reg   = 8'h01;
        cmd_wdata = 8'h5A;
        cmd_valid = 1'b1;
        wait_accept("b2b_a");
        cmd_rw    = 1'b1;
        cmd_dev   = 7'h21;
        cmd_reg   = 8'h02;
        cmd_wdata = 8'h77;
        rdy_bad = 0;
        n = 0;
        while (rsp_cnt < 3 && n < 20000) begin
            if (cmd_ready) rdy_bad++;
            tick();
            n++;
        end
        check("b2b_rsp1_bound", 32'(n < 20000), 32'd1);
        check("b2b_busy_ready", 32'(rdy_bad), 32'd0);
        check("b2b_eng_cnt1", 32'(eng_cnt), 32'd8);
        check("b2b_a_byte0", 32'(eng_log[6]), 32'h2001);
        check("b2b_a_byte1", 32'(eng_log[7]), 32'h205A);
        wait_accept("b2b_b");
        cmd_valid = 1'b0;
        wait_rsp("b2b_rsp2", 4);
        check("b2b_eng_cnt2", 32'(eng_cnt), 32'd10);
        check("b2b_b_byte0", 32'(eng_log[8]), 32'h2102);
        check("b2b_b_byte1", 32'(eng_log[9]), 32'hA100);
        check("b2b_rdata", 32'(last_rdata), 32'h9C);
        check("b2b_err", 32'(last_err), 32'd0);

        // Watchdog abort: engine never drops ready
        cmd_rw       = 1'b0;
        cmd_dev      = 7'h11;
        cmd_reg      = 8'h22;
        cmd_wdata    = 8'h33;
        cmd_valid_to = 1'b1;
        n = 0;
        while (!cmd_ready_to && n < 100) begin
            tick();
            n++;
        end
        @(posedge clk);
        #1;
        cmd_valid_to = 1'b0;
        check("to_addr", 32'(i2c_addr_to), 32'h11);
        check("to_data", 32'(i2c_data_to), 32'h22);
        check("to_rw", 32'(i2c_rw_to), 32'd0);
        n = 0;
        while (rsp_cnt_to < 1 && n < 3000) begin
            tick();
            n++;
        end
        check("to_rsp_bound", 32'(n < 3000), 32'd1);
        check("to_enable_cycles", 32'(en_hi_to), 32'd1000);
        check("to_err", 32'(last_err_to), 32'd1);
        check("to_rdata_kept", 32'(rsp_rdata_to), 32'h00);
        tick();
        check("to_enable_low", 32'(i2c_enable_to), 32'd0);
        check("to_idle_ready", 32'(cmd_ready_to), 32'd1);
        check("to_rsp_once", 32'(rsp_cnt_to), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
